branch_resolve_queue: RTL and testbench

Retire-side companion to the two-level branch predictor. Holds prediction metadata (PHT index, BHT index, predicted direction) for every in-flight branch from fetch until retirement. Accepts out-of-order resolution from execute, retires in program order, and drives the predictor's update port (update_en, update_PHT_index, update_BHT_index, branch_en). Flags mispredictions and squashes younger entries.

---
 rtl/branch_resolve_queue.sv | 134 +++++++++++++
 tb/tb_branch_resolve_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// In-order retire queue for predicted branches: out-of-order resolve, in-order
// predictor update, mispredict flagging with squash of younger entries.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic [6:0]       alloc_PHT_index,
    input  logic [3:0]       alloc_BHT_index,
    input  logic             alloc_taken,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_tag,
    input  logic             resolve_taken,
    output logic             update_en,
    output logic [6:0]       update_PHT_index,
    output logic [3:0]       update_BHT_index,
    output logic             branch_en,
    output logic             mispredict,
    output logic [TAG_W-1:0] mispredict_tag
);

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] resolved_r;
    logic [DEPTH-1:0] pred_r;
    logic [DEPTH-1:0] act_r;
    logic [6:0]       pht_r [DEPTH];
    logic [3:0]       bht_r [DEPTH];
    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [TAG_W:0]   count_r;

    logic             accept_s;
    logic             mis_s;
    logic             retire_s;
    logic             alloc_s;
    logic [TAG_W-1:0] res_age_s;
    logic [DEPTH-1:0] squash_s;

    assign alloc_ready = (count_r < (TAG_W+1)'(DEPTH));
    assign alloc_tag   = tail_r;

    // Event decode; retire sees only resolves committed on earlier edges.
    always_comb begin
        logic [TAG_W-1:0] age_v;
        accept_s  = resolve_valid & valid_r[resolve_tag] & ~resolved_r[resolve_tag];
        mis_s     = accept_s & (resolve_taken != pred_r[resolve_tag]);
        retire_s  = valid_r[head_r] & resolved_r[head_r];
        alloc_s   = alloc_valid & alloc_ready & ~mis_s;
        res_age_s = resolve_tag - head_r;
        age_v     = '0;
        squash_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_v       = TAG_W'(i) - head_r;
            squash_s[i] = mis_s & (age_v > res_age_s);
        end
    end

    // Head/tail pointers and occupancy; a mispredict rewinds tail to just past the bad branch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (retire_s) begin
                head_r <= head_r + TAG_W'(1);
            end
            if (mis_s) begin
                tail_r  <= resolve_tag + TAG_W'(1);
                count_r <= {1'b0, res_age_s} + (TAG_W+1)'(1) - (TAG_W+1)'(retire_s);
            end else begin
                tail_r  <= tail_r + TAG_W'(alloc_s);
                count_r <= count_r + (TAG_W+1)'(alloc_s) - (TAG_W+1)'(retire_s);
            end
        end
    end

    // Per-entry state: alloc at tail, resolve by tag, clear on retire or squash.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r    <= '0;
            resolved_r <= '0;
            pred_r     <= '0;
            act_r      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pht_r[i] <= 7'd0;
                bht_r[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_s[i] || (retire_s && (TAG_W'(i) == head_r))) begin
                    valid_r[i] <= 1'b0;
                end else if (alloc_s && (TAG_W'(i) == tail_r)) begin
                    valid_r[i]    <= 1'b1;
                    resolved_r[i] <= 1'b0;
                    pred_r[i]     <= alloc_taken;
                    pht_r[i]      <= alloc_PHT_index;
                    bht_r[i]      <= alloc_BHT_index;
                end else if (accept_s && (TAG_W'(i) == resolve_tag)) begin
                    resolved_r[i] <= 1'b1;
                    act_r[i]      <= resolve_taken;
                end
            end
        end
    end

    // Registered predictor update and mispredict pulses; payloads hold between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            update_en        <= 1'b0;
            update_PHT_index <= 7'd0;
            update_BHT_index <= 4'd0;
            branch_en        <= 1'b0;
            mispredict       <= 1'b0;
            mispredict_tag   <= '0;
        end else begin
            update_en  <= retire_s;
            mispredict <= mis_s;
            if (retire_s) begin
                update_PHT_index <= pht_r[head_r];
                update_BHT_index <= bht_r[head_r];
                branch_en        <= act_r[head_r];
            end
            if (mis_s) begin
                mispredict_tag <= resolve_tag;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a program-order
// queue model of in-flight branches.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_valid = 1'b0;
    logic [6:0] alloc_PHT_index = 7'd0;
    logic [3:0] alloc_BHT_index = 4'd0;
    logic       alloc_taken = 1'b0;
    logic       alloc_ready;
    logic [2:0] alloc_tag;
    logic       resolve_valid = 1'b0;
    logic [2:0] resolve_tag = 3'd0;
    logic       resolve_taken = 1'b0;
    logic       update_en;
    logic [6:0] update_PHT_index;
    logic [3:0] update_BHT_index;
    logic       branch_en;
    logic       mispredict;
    logic [2:0] mispredict_tag;

    branch_resolve_queue #(.DEPTH(DEPTH), .TAG_W(3)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_PHT_index(alloc_PHT_index),
        .alloc_BHT_index(alloc_BHT_index), .alloc_taken(alloc_taken),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_taken(resolve_taken),
        .update_en(update_en), .update_PHT_index(update_PHT_index),
        .update_BHT_index(update_BHT_index), .branch_en(branch_en),
        .mispredict(mispredict), .mispredict_tag(mispredict_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] tag;
        logic [6:0] pht;
        logic [3:0] bht;
        bit         pred;
        bit         res;
        bit         act;
    } ent_t;

    ent_t       q[$];
    logic [2:0] m_tail = 3'd0;
    bit         e_upd = 1'b0;
    logic [6:0] e_pht = 7'd0;
    logic [3:0] e_bht = 4'd0;
    bit         e_br = 1'b0;
    bit         e_mis = 1'b0;
    logic [2:0] e_mtag = 3'd0;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check("update_en", 32'(update_en), 32'(e_upd));
        check("update_pht", 32'(update_PHT_index), 32'(e_pht));
        check("update_bht", 32'(update_BHT_index), 32'(e_bht));
        check("branch_en", 32'(branch_en), 32'(e_br));
        check("mispredict", 32'(mispredict), 32'(e_mis));
        check("mispredict_tag", 32'(mispredict_tag), 32'(e_mtag));
        check("alloc_ready", 32'(alloc_ready), 32'(q.size() < DEPTH));
        check("alloc_tag", 32'(alloc_tag), 32'(m_tail));
    endtask

    // One clock: drive inputs, advance the model across the edge, compare after it.
    task automatic step(input bit av, input logic [6:0] ap, input logic [3:0] ab, input bit at,
                        input bit rv, input logic [2:0] rt, input bit rk);
        int   p;
        bit   acc, mis, ret;
        ent_t e;
        alloc_valid = av; alloc_PHT_index = ap; alloc_BHT_index = ab; alloc_taken = at;
        resolve_valid = rv; resolve_tag = rt; resolve_taken = rk;
        @(posedge clk);
        ret = (q.size() > 0) && q[0].res;
        p = -1;
        for (int i = 0; i < q.size(); i++) if (q[i].tag == rt) p = i;
        acc = rv && (p >= 0) && !q[p].res;
        mis = acc && (rk != q[p].pred);
        if (acc) begin
            q[p].res = 1'b1;
            q[p].act = rk;
        end
        if (mis) begin
            while (q.size() > p + 1) void'(q.pop_back());
            m_tail = rt + 3'd1;
        end else if (av && q.size() < DEPTH) begin
            e.tag = m_tail; e.pht = ap; e.bht = ab; e.pred = at; e.res = 1'b0; e.act = 1'b0;
            q.push_back(e);
            m_tail = m_tail + 3'd1;
        end
        e_upd = ret;
        if (ret) begin
            e = q.pop_front();
            e_pht = e.pht; e_bht = e.bht; e_br = e.act;
        end
        e_mis = mis;
        if (mis) e_mtag = rt;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic alloc(input logic [6:0] ap, input bit at);
        step(1'b1, ap, ap[3:0], at, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic resolve(input logic [2:0] rt, input bit rk);
        step(1'b0, 7'd0, 4'd0, 1'b0, 1'b1, rt, rk);
    endtask

    // Reset asserted between edges must clear outputs without waiting for a clock.
    task automatic do_reset();
        alloc_valid = 1'b0; resolve_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        q.delete();
        m_tail = 3'd0; e_upd = 1'b0; e_pht = 7'd0; e_bht = 4'd0; e_br = 1'b0;
        e_mis = 1'b0; e_mtag = 3'd0;
        check_all();
        @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        bit         av, rv, rk, at;
        logic [2:0] rt;
        int         k;

        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1 check_all();

        // In-order stream
        alloc(7'h11, 1'b1); alloc(7'h22, 1'b1); alloc(7'h33, 1'b1);
        resolve(3'd0, 1'b1); resolve(3'd1, 1'b1); resolve(3'd2, 1'b1);
        idle(3);

        // Out-of-order resolve
        do_reset();
        for (int i = 0; i < 4; i++) alloc(7'(8'h40 + i), 1'b0);
        resolve(3'd3, 1'b0); resolve(3'd2, 1'b1); resolve(3'd1, 1'b0); resolve(3'd0, 1'b0);
        idle(6);

        // Mispredict squash
        do_reset();
        for (int i = 0; i < 6; i++) alloc(7'(8'h50 + i), 1'b1);
        resolve(3'd2, 1'b0);
        check("squash_tag", 32'(alloc_tag), 32'd3);
        for (int i = 3; i < 6; i++) resolve(3'(i), 1'b1);
        resolve(3'd0, 1'b1); resolve(3'd1, 1'b1);
        idle(4);

        // Full and wrap
        do_reset();
        for (int i = 0; i < 8; i++) alloc(7'(8'h60 + i), 1'b1);
        check("full_ready", 32'(alloc_ready), 32'd0);
        alloc(7'h7f, 1'b1);
        resolve(3'd0, 1'b1); resolve(3'd1, 1'b1);
        idle(2);
        alloc(7'h70, 1'b1); alloc(7'h71, 1'b1);
        for (int i = 2; i < 6; i++) resolve(3'(i), 1'b1);
        idle(2);
        resolve(3'd1, 1'b0);
        check("wrap_tail", 32'(alloc_tag), 32'd2);
        idle(1);

        // Simultaneous retire, alloc and mispredicting resolve
        do_reset();
        alloc(7'h0a, 1'b1); alloc(7'h0b, 1'b1);
        resolve(3'd0, 1'b1);
        step(1'b1, 7'h0c, 4'hc, 1'b1, 1'b1, 3'd1, 1'b0);
        check("simul_tag", 32'(alloc_tag), 32'd2);
        idle(3);

        // Randomized traffic with one mid-stream reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            av = ($urandom % 3) != 0;
            at = $urandom % 2;
            rv = (q.size() > 0) ? ($urandom % 2) : ($urandom % 8 == 0);
            rt = 3'($urandom);
            rk = $urandom % 2;
            if (q.size() > 0 && ($urandom % 4) != 0) begin
                k  = $urandom % q.size();
                rt = q[k].tag;
                rk = ($urandom % 8 == 0) ? !q[k].pred : q[k].pred;
            end
            step(av, 7'($urandom), 4'($urandom), at, rv, rt, rk);
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
